// File: rtl/decoder_scan_n_pkg.sv
// Shared types and helpers for the scanning N-to-2^N decoder.
package decoder_pkg;

  localparam int unsigned MAX_ADDR_W = 8;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_e;

  // Callers cast the result down to their own 2**ADDR_W output width.
  function automatic logic [(1 << MAX_ADDR_W)-1:0] onehot(input logic [MAX_ADDR_W-1:0] addr);
    onehot       = '0;
    onehot[addr] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_scan_n_if.sv
// Control/status bundle between the controlling logic and decoder_scan_n.
interface decoder_scan_n_if #(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DWELL_W = 8
);
  logic                     en;
  logic                     mode;
  logic [ADDR_W-1:0]        addr_in;
  logic                     load;
  logic                     dir;
  logic [DWELL_W-1:0]       dwell;
  logic [(2**ADDR_W)-1:0]   dec_out;
  logic [ADDR_W-1:0]        cur_addr;
  logic                     wrap;

  modport master (
    output en, mode, addr_in, load, dir, dwell,
    input  dec_out, cur_addr, wrap
  );

  modport slave (
    input  en, mode, addr_in, load, dir, dwell,
    output dec_out, cur_addr, wrap
  );
endinterface

// File: rtl/decoder_scan_n_scan_counter.sv
// Address counter with dwell prescaler, load, direction and wrap pulse.
module scan_counter
  import decoder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  state_e             state_i,
  input  logic               restart_i,
  input  logic               load_i,
  input  logic               dir_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic [ADDR_W-1:0]  addr_in_i,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [ADDR_W-1:0]  addr_next_o,
  output logic               wrap_o
);

  logic [DWELL_W-1:0] presc_q, presc_d, presc_eff;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               wrap_q, wrap_d;
  logic               advance;

  // IDLE holds the prescaler, so a fresh SCAN entry must ignore the held count.
  assign presc_eff = restart_i ? '0 : presc_q;
  assign advance   = (presc_eff >= dwell_i);

  always_comb begin
    presc_d = presc_q;
    addr_d  = addr_q;
    wrap_d  = 1'b0;
    case (state_i)
      DIRECT: begin
        addr_d  = addr_in_i;
        presc_d = '0;
      end
      SCAN: begin
        if (load_i) begin
          addr_d  = addr_in_i;
          presc_d = '0;
        end else if (advance) begin
          presc_d = '0;
          if (dir_i) begin
            addr_d = addr_q - 1'b1;
            wrap_d = (addr_q == '0);
          end else begin
            addr_d = addr_q + 1'b1;
            wrap_d = (addr_q == '1);
          end
        end else begin
          presc_d = presc_eff + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      addr_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      addr_q  <= addr_d;
      wrap_q  <= wrap_d;
    end
  end

  assign addr_o      = addr_q;
  assign addr_next_o = addr_d;
  assign wrap_o      = wrap_q;

endmodule

// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N decoder with direct and self-scanning modes.
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned ACTIVE_LOW = 0
) (
  input logic              clk,
  input logic              rst_n,
  decoder_scan_n_if.slave  bus
);

  localparam int unsigned OUT_W = 2**ADDR_W;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   dec_q, dec_d;
  logic [ADDR_W-1:0]  addr_cur, addr_next;
  logic               wrap_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
    end
  end

  // The state chosen for this edge is what the counter and decode act on.
  always_comb begin
    state_d = IDLE;
    dec_d   = '0;
    if (bus.en) begin
      state_d = (bus.mode == MODE_SCAN) ? SCAN : DIRECT;
    end
    if (state_d != IDLE) begin
      dec_d = OUT_W'(onehot(MAX_ADDR_W'(addr_next)));
    end
  end

  scan_counter #(
    .ADDR_W  (ADDR_W),
    .DWELL_W (DWELL_W)
  ) u_scan_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .state_i     (state_d),
    .restart_i   (state_q != SCAN),
    .load_i      (bus.load),
    .dir_i       (bus.dir),
    .dwell_i     (bus.dwell),
    .addr_in_i   (bus.addr_in),
    .addr_o      (addr_cur),
    .addr_next_o (addr_next),
    .wrap_o      (wrap_cur)
  );

  assign bus.dec_out  = (ACTIVE_LOW != 0) ? ~dec_q : dec_q;
  assign bus.cur_addr = addr_cur;
  assign bus.wrap     = wrap_cur;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench for decoder_scan_n: active-high and active-low instances.
module tb_decoder_scan_n;

  logic clk;
  logic rst_n;

  decoder_scan_n_if #(.ADDR_W(3), .DWELL_W(8)) ifa ();
  decoder_scan_n_if #(.ADDR_W(3), .DWELL_W(8)) ifb ();

  decoder_scan_n #(.ADDR_W(3), .DWELL_W(8), .ACTIVE_LOW(0)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa.slave)
  );
  decoder_scan_n #(.ADDR_W(3), .DWELL_W(8), .ACTIVE_LOW(1)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb.slave)
  );

  typedef struct {
    bit         inst_b;
    logic [7:0] dec;
    logic [2:0] cur;
    logic       wrap;
    string      tag;
  } exp_t;

  typedef struct {
    logic       en;
    logic       mode;
    logic       load;
    logic       dir;
    logic [7:0] dwell;
    logic [2:0] addr;
    logic [2:0] cur;
    logic       wrap;
    logic       act;
  } row_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] oh(input logic [2:0] a);
    logic [7:0] one;
    one = 8'h01;
    return one << a;
  endfunction

  task automatic test_reset();
    exp_t e;
    #2;
    sbq.push_back('{1'b0, 8'h00, 3'd0, 1'b0, "reset_a"});
    e = sbq.pop_front();
    checks++;
    if ({ifa.dec_out, ifa.cur_addr, ifa.wrap} !== {e.dec, e.cur, e.wrap}) begin
      failures++;
      $display("FAIL %s: got dec=%h cur=%0d wrap=%b, need dec=%h cur=%0d wrap=%b",
               e.tag, ifa.dec_out, ifa.cur_addr, ifa.wrap, e.dec, e.cur, e.wrap);
    end
    checks++;
    if (ifb.dec_out !== 8'hFF) begin
      failures++;
      $display("FAIL reset_b: got dec=%h, need dec=ff", ifb.dec_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_direct_sweep();
    exp_t e;
    ifa.en = 1'b1; ifa.mode = 1'b0; ifa.load = 1'b0; ifa.dir = 1'b0; ifa.dwell = 8'd0;
    for (int unsigned i = 0; i < 8; i++) begin
      ifa.addr_in = 3'(i);
      sbq.push_back('{1'b0, oh(3'(i)), 3'(i), 1'b0, $sformatf("direct_%0d", i)});
      tick();
      e = sbq.pop_front();
      checks++;
      if ({ifa.dec_out, ifa.cur_addr, ifa.wrap} !== {e.dec, e.cur, e.wrap}) begin
        failures++;
        $display("FAIL %s: got dec=%h cur=%0d wrap=%b, need dec=%h cur=%0d wrap=%b",
                 e.tag, ifa.dec_out, ifa.cur_addr, ifa.wrap, e.dec, e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_scan_up();
    exp_t e;
    logic [2:0] c;
    @(negedge clk);
    rst_n = 1'b0;
    ifa.en = 1'b1; ifa.mode = 1'b1; ifa.load = 1'b0; ifa.dir = 1'b0; ifa.dwell = 8'd2;
    @(negedge clk);
    rst_n = 1'b1;
    // each address is visible for 3 clocks, counting the reset interval for address 0
    for (int unsigned k = 1; k <= 27; k++) begin
      c = 3'((k / 3) % 8);
      sbq.push_back('{1'b0, oh(c), c, (k % 3 == 0) && (c == 3'd0), $sformatf("scan_up_%0d", k)});
      tick();
      e = sbq.pop_front();
      checks++;
      if ({ifa.dec_out, ifa.cur_addr, ifa.wrap} !== {e.dec, e.cur, e.wrap}) begin
        failures++;
        $display("FAIL %s: got dec=%h cur=%0d wrap=%b, need dec=%h cur=%0d wrap=%b",
                 e.tag, ifa.dec_out, ifa.cur_addr, ifa.wrap, e.dec, e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_scan_down_load();
    exp_t e;
    row_t rows [12] = '{
      '{1, 1, 1, 1, 8'd0, 3'd5, 3'd5, 0, 1},
      '{1, 1, 0, 1, 8'd0, 3'd5, 3'd4, 0, 1},
      '{1, 1, 0, 1, 8'd0, 3'd5, 3'd3, 0, 1},
      '{1, 1, 0, 1, 8'd0, 3'd5, 3'd2, 0, 1},
      '{1, 1, 0, 1, 8'd0, 3'd5, 3'd1, 0, 1},
      '{1, 1, 0, 1, 8'd0, 3'd5, 3'd0, 0, 1},
      '{1, 1, 0, 1, 8'd0, 3'd5, 3'd7, 1, 1},
      '{1, 1, 0, 1, 8'd0, 3'd5, 3'd6, 0, 1},
      '{1, 1, 1, 1, 8'd0, 3'd2, 3'd2, 0, 1},
      '{1, 1, 0, 1, 8'd0, 3'd2, 3'd1, 0, 1},
      '{1, 1, 0, 1, 8'd0, 3'd2, 3'd0, 0, 1},
      '{1, 1, 1, 1, 8'd0, 3'd3, 3'd3, 0, 1}
    };
    foreach (rows[i]) begin
      ifa.en = rows[i].en; ifa.mode = rows[i].mode; ifa.load = rows[i].load;
      ifa.dir = rows[i].dir; ifa.dwell = rows[i].dwell; ifa.addr_in = rows[i].addr;
      sbq.push_back('{1'b0, rows[i].act ? oh(rows[i].cur) : 8'h00, rows[i].cur, rows[i].wrap,
                      $sformatf("scan_down_%0d", i)});
      tick();
      e = sbq.pop_front();
      checks++;
      if ({ifa.dec_out, ifa.cur_addr, ifa.wrap} !== {e.dec, e.cur, e.wrap}) begin
        failures++;
        $display("FAIL %s: got dec=%h cur=%0d wrap=%b, need dec=%h cur=%0d wrap=%b",
                 e.tag, ifa.dec_out, ifa.cur_addr, ifa.wrap, e.dec, e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_dwell_dir_change();
    exp_t e;
    row_t rows [8] = '{
      '{1, 1, 1, 0, 8'd5, 3'd0, 3'd0, 0, 1},
      '{1, 1, 0, 0, 8'd5, 3'd0, 3'd0, 0, 1},
      '{1, 1, 0, 0, 8'd5, 3'd0, 3'd0, 0, 1},
      '{1, 1, 0, 0, 8'd1, 3'd0, 3'd1, 0, 1},
      '{1, 1, 0, 0, 8'd1, 3'd0, 3'd1, 0, 1},
      '{1, 1, 0, 0, 8'd1, 3'd0, 3'd2, 0, 1},
      '{1, 1, 0, 1, 8'd1, 3'd0, 3'd2, 0, 1},
      '{1, 1, 0, 1, 8'd1, 3'd0, 3'd1, 0, 1}
    };
    foreach (rows[i]) begin
      ifa.en = rows[i].en; ifa.mode = rows[i].mode; ifa.load = rows[i].load;
      ifa.dir = rows[i].dir; ifa.dwell = rows[i].dwell; ifa.addr_in = rows[i].addr;
      sbq.push_back('{1'b0, rows[i].act ? oh(rows[i].cur) : 8'h00, rows[i].cur, rows[i].wrap,
                      $sformatf("dwell_dir_%0d", i)});
      tick();
      e = sbq.pop_front();
      checks++;
      if ({ifa.dec_out, ifa.cur_addr, ifa.wrap} !== {e.dec, e.cur, e.wrap}) begin
        failures++;
        $display("FAIL %s: got dec=%h cur=%0d wrap=%b, need dec=%h cur=%0d wrap=%b",
                 e.tag, ifa.dec_out, ifa.cur_addr, ifa.wrap, e.dec, e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_enable_mode();
    exp_t e;
    row_t rows [10] = '{
      '{1, 1, 1, 0, 8'd3, 3'd4, 3'd4, 0, 1},
      '{0, 1, 0, 0, 8'd3, 3'd4, 3'd4, 0, 0},
      '{0, 1, 0, 0, 8'd3, 3'd4, 3'd4, 0, 0},
      '{0, 1, 0, 0, 8'd3, 3'd4, 3'd4, 0, 0},
      '{1, 0, 0, 0, 8'd3, 3'd6, 3'd6, 0, 1},
      '{1, 1, 0, 0, 8'd1, 3'd6, 3'd6, 0, 1},
      '{1, 1, 0, 0, 8'd1, 3'd6, 3'd7, 0, 1},
      '{1, 1, 0, 0, 8'd1, 3'd6, 3'd7, 0, 1},
      '{1, 1, 0, 0, 8'd1, 3'd6, 3'd0, 1, 1},
      '{1, 1, 0, 0, 8'd1, 3'd6, 3'd0, 0, 1}
    };
    foreach (rows[i]) begin
      ifa.en = rows[i].en; ifa.mode = rows[i].mode; ifa.load = rows[i].load;
      ifa.dir = rows[i].dir; ifa.dwell = rows[i].dwell; ifa.addr_in = rows[i].addr;
      sbq.push_back('{1'b0, rows[i].act ? oh(rows[i].cur) : 8'h00, rows[i].cur, rows[i].wrap,
                      $sformatf("enable_mode_%0d", i)});
      tick();
      e = sbq.pop_front();
      checks++;
      if ({ifa.dec_out, ifa.cur_addr, ifa.wrap} !== {e.dec, e.cur, e.wrap}) begin
        failures++;
        $display("FAIL %s: got dec=%h cur=%0d wrap=%b, need dec=%h cur=%0d wrap=%b",
                 e.tag, ifa.dec_out, ifa.cur_addr, ifa.wrap, e.dec, e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    ifa.en = 1'b1; ifa.mode = 1'b1; ifa.load = 1'b0; ifa.dir = 1'b0; ifa.dwell = 8'd0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    sbq.push_back('{1'b0, 8'h00, 3'd0, 1'b0, "async_reset_a"});
    e = sbq.pop_front();
    checks++;
    if ({ifa.dec_out, ifa.cur_addr, ifa.wrap} !== {e.dec, e.cur, e.wrap}) begin
      failures++;
      $display("FAIL %s: got dec=%h cur=%0d wrap=%b, need dec=%h cur=%0d wrap=%b",
               e.tag, ifa.dec_out, ifa.cur_addr, ifa.wrap, e.dec, e.cur, e.wrap);
    end
    checks++;
    if (ifb.dec_out !== 8'hFF) begin
      failures++;
      $display("FAIL async_reset_b: got dec=%h, need dec=ff", ifb.dec_out);
    end
    ifa.dwell = 8'd1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned k = 1; k <= 4; k++) begin
      sbq.push_back('{1'b0, oh(3'(k / 2)), 3'(k / 2), 1'b0, $sformatf("resume_%0d", k)});
      tick();
      e = sbq.pop_front();
      checks++;
      if ({ifa.dec_out, ifa.cur_addr, ifa.wrap} !== {e.dec, e.cur, e.wrap}) begin
        failures++;
        $display("FAIL %s: got dec=%h cur=%0d wrap=%b, need dec=%h cur=%0d wrap=%b",
                 e.tag, ifa.dec_out, ifa.cur_addr, ifa.wrap, e.dec, e.cur, e.wrap);
      end
    end
  endtask

  task automatic test_polarity();
    exp_t e;
    ifb.mode = 1'b0; ifb.load = 1'b0; ifb.dir = 1'b0; ifb.dwell = 8'd0;
    for (int unsigned i = 0; i < 3; i++) begin
      ifb.en      = (i != 2);
      ifb.addr_in = (i == 0) ? 3'd3 : 3'd0;
      sbq.push_back('{1'b1, (i == 0) ? 8'hF7 : (i == 1) ? 8'hFE : 8'hFF,
                      3'd0 + ((i == 0) ? 3'd3 : 3'd0), 1'b0, $sformatf("polarity_%0d", i)});
      tick();
      e = sbq.pop_front();
      checks++;
      if ({ifb.dec_out, ifb.cur_addr, ifb.wrap} !== {e.dec, e.cur, e.wrap}) begin
        failures++;
        $display("FAIL %s: got dec=%h cur=%0d wrap=%b, need dec=%h cur=%0d wrap=%b",
                 e.tag, ifb.dec_out, ifb.cur_addr, ifb.wrap, e.dec, e.cur, e.wrap);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    ifa.en = 1'b0; ifa.mode = 1'b0; ifa.addr_in = '0; ifa.load = 1'b0; ifa.dir = 1'b0; ifa.dwell = '0;
    ifb.en = 1'b0; ifb.mode = 1'b0; ifb.addr_in = '0; ifb.load = 1'b0; ifb.dir = 1'b0; ifb.dwell = '0;
    #1;
    rst_n = 1'b0;
    test_reset();
    test_direct_sweep();
    test_scan_up();
    test_scan_down_load();
    test_dwell_dir_change();
    test_enable_mode();
    test_async_reset();
    test_polarity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
Parametrised, registered N-to-2^N one-hot decoder. It succeeds the fixed 3-to-8 combinational decoder.
- Direct mode: registers a decode of an external address.
- Scan mode: an internal address counter with programmable dwell sweeps the outputs up or down, for digit/row strobing and bench stimulus generation.
- Sits between control logic and strobed loads such as LED digits or keypad rows.

Parameters:
ADDR_W, 3, address width; output width is 2**ADDR_W
DWELL_W, 8, width of the dwell (cycles-per-step) control
ACTIVE_LOW, 0, 1 = selected output driven 0 and others 1; 0 = one-hot high

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  enable; 0 forces all outputs inactive
mode  in  1  0 = direct decode, 1 = scan
addr_in  in  ADDR_W  direct-mode address; scan-mode load value
load  in  1  scan mode: load addr_in into the counter
dir  in  1  scan direction: 0 = up, 1 = down
dwell  in  DWELL_W  scan step period minus 1, in clocks
dec_out  out  2**ADDR_W  decoded one-hot (or one-cold) outputs
cur_addr  out  ADDR_W  address currently decoded on dec_out
wrap  out  1  one-cycle pulse when the scan counter wraps

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - dec_out all inactive: all 0, or all 1 if ACTIVE_LOW.
  - cur_addr = 0, wrap = 0, prescaler = 0, state = IDLE.
- States, evaluated every clock:
  - IDLE: en=0.
  - DIRECT: en=1, mode=0.
  - SCAN: en=1, mode=1.
  - Any state may move to any other in one clock.
- IDLE:
  - dec_out goes inactive on the next edge; cur_addr and the prescaler hold.
  - wrap = 0.
- DIRECT:
  - cur_addr <= addr_in each clock; dec_out <= decode(addr_in).
  - Latency is 1 clock.
  - Prescaler cleared; wrap = 0; load and dir are ignored.
- SCAN:
  - Advance condition: prescaler >= dwell. On advance the prescaler goes to 0 and cur_addr steps by ±1 mod 2**ADDR_W. Otherwise the prescaler increments.
  - dwell=0 advances every clock, so each address is shown for (dwell+1) clocks.
  - Using >= means a dwell lowered mid-step takes effect at the next edge without overrun.
  - dec_out always reflects cur_addr on the same clock (registered together).
- load in SCAN:
  - cur_addr <= addr_in and prescaler <= 0.
  - load beats a same-cycle advance; wrap is not asserted on a load.
- wrap:
  - Asserted for exactly the cycle after an advance from 2**ADDR_W-1 to 0 (up) or from 0 to 2**ADDR_W-1 (down).
- dir change: takes effect on the next advance; the prescaler is not disturbed.
- Entering SCAN from DIRECT or IDLE: scan resumes from the current cur_addr, prescaler starting at 0.
- Exactly one dec_out bit is active whenever the state is DIRECT or SCAN; none is active in IDLE or reset.
- Asynchronous reset mid-scan forces the reset values immediately; scanning restarts from address 0 after release.
- ACTIVE_LOW is applied as a final inversion only; all internal logic is polarity-independent.

Decomposition:
- Shared package decoder_pkg:
  - mode encodings MODE_DIRECT = 0, MODE_SCAN = 1
  - state encodings IDLE, DIRECT, SCAN
  - function onehot(addr) returning the 2**ADDR_W-bit vector
- One natural sub-module, scan_counter: prescaler, address counter, load, dir and wrap generation.
- The top level holds the FSM, decode register and polarity inversion.

Test Plan:
(All scenarios use ADDR_W=3, ACTIVE_LOW=0 unless stated.)
- Direct sweep: en=1, mode=0, addr_in = 0..7 one per clock -> dec_out = 0x01, 0x02, ... 0x80, each one clock after its address; wrap stays 0.
- Scan up: mode=1, dwell=2, dir=0 from reset -> cur_addr holds each value 3 clocks, 0→1→…→7→0. wrap pulses once on the 7→0 step; dec_out goes 0x80→0x01.
- Scan down with load: dwell=0, dir=1, load=1 with addr_in=5 -> cur_addr 5,4,3,2,1,0,7. wrap pulses on the 0→7 step; a load coincident with an advance yields addr_in, not the stepped value.
- Enable/mode interplay: mid-scan at cur_addr=4 drop en for 3 clocks -> dec_out = 0x00 and cur_addr = 4 held. Raise en with mode=0, addr_in=6 -> dec_out = 0x40 next clock.
- Reset mid-operation: assert rst_n=0 asynchronously between edges during scan -> dec_out = 0x00, cur_addr = 0, wrap = 0 without a clock edge. Scan resumes from 0 after release.
- Polarity: ACTIVE_LOW=1, direct addr_in=3 -> dec_out = 0xF7. IDLE and reset give 0xFF.
